// File: rtl/stack_ctrl.sv
// Stack pointer/controller: TOS held in a register, deeper entries in an external 2-port memory.
// Ops complete at the next clk edge; ready drops in FAULT until clr.
module stack_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clr,
    output logic             ready,
    output logic [WIDTH-1:0] tos,
    output logic             empty,
    output logic             full,
    output logic [DEPTH:0]   count,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [DEPTH-1:0] mem_ra,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             mem_we,
    output logic [DEPTH-1:0] mem_wa,
    output logic [WIDTH-1:0] mem_wd
);

    typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

    localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};
    localparam logic [DEPTH:0] TWO = ONE + ONE;

    state_t           r_state;
    logic [DEPTH:0]   r_count;
    logic [WIDTH-1:0] r_tos;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic             w_run;
    logic [DEPTH:0]   w_cnt_m1;
    logic [DEPTH:0]   w_cnt_m2;

    assign w_full   = (r_count == CAP);
    assign w_empty  = (r_count == '0);
    assign w_run    = (r_state == RUN);
    assign w_cnt_m1 = r_count - ONE;
    assign w_cnt_m2 = r_count - TWO;

    assign ready         = w_run;
    assign tos           = r_tos;
    assign empty         = w_empty;
    assign full          = w_full;
    assign count         = r_count;
    assign err_overflow  = r_ovf;
    assign err_underflow = r_unf;

    // The old TOS spills to memory only on a plain push onto a non-empty, non-full stack.
    assign mem_ra = w_cnt_m2[DEPTH-1:0];
    assign mem_wa = w_cnt_m1[DEPTH-1:0];
    assign mem_wd = r_tos;
    assign mem_we = !resetq && w_run && !clr && push && !pop && !w_empty && !w_full;

    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            r_state <= RUN;
            r_count <= '0;
            r_tos   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clr) begin
            r_state <= RUN;
            r_count <= '0;
            r_tos   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (r_state == RUN) begin
            case ({push, pop})
                2'b10: begin
                    if (w_full) begin
                        r_ovf   <= 1'b1;
                        r_state <= FAULT;
                    end else begin
                        r_tos   <= push_data;
                        r_count <= r_count + ONE;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        r_unf   <= 1'b1;
                        r_state <= FAULT;
                    end else begin
                        r_tos   <= (r_count >= TWO) ? mem_rd : '0;
                        r_count <= w_cnt_m1;
                    end
                end
                2'b11: begin
                    // Replace; on an empty stack this degenerates to a plain push.
                    r_tos <= push_data;
                    if (w_empty) begin
                        r_count <= ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl at DEPTH=2 with a behavioural two-port memory.
module tb_stack_ctrl;

    localparam int DEPTH = 2;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             resetq = 1'b1;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_data = '0;
    logic             clr = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] tos;
    logic             empty;
    logic             full;
    logic [DEPTH:0]   count;
    logic             err_overflow;
    logic             err_underflow;
    logic [DEPTH-1:0] mem_ra;
    logic [WIDTH-1:0] mem_rd;
    logic             mem_we;
    logic [DEPTH-1:0] mem_wa;
    logic [WIDTH-1:0] mem_wd;

    logic [WIDTH-1:0] mem [4];
    int               wr_cnt = 0;
    int               n_chk = 0;
    int               n_err = 0;
    int               wr_snap;

    stack_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .resetq(resetq), .push(push), .pop(pop), .push_data(push_data),
        .clr(clr), .ready(ready), .tos(tos), .empty(empty), .full(full), .count(count),
        .err_overflow(err_overflow), .err_underflow(err_underflow),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_ra];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        push = 1'b1;
        push_data = d;
        step();
        push = 1'b0;
    endtask

    logic [WIDTH-1:0] vals [4];
    logic [WIDTH-1:0] pop_exp [4];

    initial begin
        vals[0] = 16'h11; vals[1] = 16'h22; vals[2] = 16'h33; vals[3] = 16'h44;
        pop_exp[0] = 16'h33; pop_exp[1] = 16'h22; pop_exp[2] = 16'h11; pop_exp[3] = 16'h00;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_tos", 32'(tos), 0);
        check("rst_ready", 32'(ready), 1);
        check("rst_empty", 32'(empty), 1);
        check("rst_flags", {30'd0, err_overflow, err_underflow}, 0);
        check("rst_we", 32'(mem_we), 0);
        step();
        resetq = 1'b0;
        step();

        // Fill to capacity
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            push_data = vals[i];
            #1;
            check("fill_we", 32'(mem_we), (i > 0) ? 1 : 0);
            step();
            push = 1'b0;
            check("fill_count", 32'(count), i + 1);
            check("fill_tos", 32'(tos), 32'(vals[i]));
        end
        check("fill_full", 32'(full), 1);
        check("fill_wrcnt", wr_cnt, 3);
        check("mem0", 32'(mem[0]), 32'h11);
        check("mem1", 32'(mem[1]), 32'h22);
        check("mem2", 32'(mem[2]), 32'h33);
        check("full_ra", 32'(mem_ra), 2);

        // Drain
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            step();
            pop = 1'b0;
            check("drain_tos", 32'(tos), 32'(pop_exp[i]));
            check("drain_count", 32'(count), 3 - i);
        end
        check("drain_empty", 32'(empty), 1);
        check("drain_flags", {30'd0, err_overflow, err_underflow}, 0);
        check("drain_ready", 32'(ready), 1);

        // Overflow
        for (int i = 0; i < 4; i++) do_push(vals[i]);
        wr_snap = wr_cnt;
        push = 1'b1;
        push_data = 16'h55;
        #1;
        check("ovf_we", 32'(mem_we), 0);
        step();
        push = 1'b0;
        check("ovf_flag", 32'(err_overflow), 1);
        check("ovf_ready", 32'(ready), 0);
        check("ovf_tos", 32'(tos), 32'h44);
        check("ovf_count", 32'(count), 4);
        check("ovf_wrcnt", wr_cnt, wr_snap);
        pop = 1'b1;
        step();
        step();
        pop = 1'b0;
        check("fault_pop_count", 32'(count), 4);
        check("fault_pop_tos", 32'(tos), 32'h44);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_count", 32'(count), 0);
        check("clr_ready", 32'(ready), 1);
        check("clr_flags", {30'd0, err_overflow, err_underflow}, 0);

        // Underflow, then clr beats a push
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("unf_flag", 32'(err_underflow), 1);
        check("unf_ready", 32'(ready), 0);
        check("unf_tos", 32'(tos), 0);
        clr = 1'b1;
        push = 1'b1;
        push_data = 16'h77;
        step();
        clr = 1'b0;
        push = 1'b0;
        check("clrpush_count", 32'(count), 0);
        check("clrpush_tos", 32'(tos), 0);
        check("clrpush_ready", 32'(ready), 1);
        check("clrpush_unf", 32'(err_underflow), 0);

        // Replace
        do_push(16'h10);
        do_push(16'h20);
        wr_snap = wr_cnt;
        push = 1'b1;
        pop = 1'b1;
        push_data = 16'h99;
        #1;
        check("rep_we", 32'(mem_we), 0);
        step();
        push = 1'b0;
        pop = 1'b0;
        check("rep_tos", 32'(tos), 32'h99);
        check("rep_count", 32'(count), 2);
        check("rep_mem0", 32'(mem[0]), 32'h10);
        check("rep_wrcnt", wr_cnt, wr_snap);
        pop = 1'b1;
        step();
        pop = 1'b0;
        check("rep_pop_tos", 32'(tos), 32'h10);
        check("rep_pop_count", 32'(count), 1);

        // Asynchronous reset mid-push
        push = 1'b1;
        push_data = 16'hAB;
        #1;
        check("pre_rst_we", 32'(mem_we), 1);
        #1;
        resetq = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_tos", 32'(tos), 0);
        check("arst_we", 32'(mem_we), 0);
        wr_snap = wr_cnt;
        step();
        check("arst_wrcnt", wr_cnt, wr_snap);
        check("arst_count_hold", 32'(count), 0);
        push = 1'b0;
        resetq = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Pointer/controller front end for the two-port stack memory (async read port ra/rd, sync write port we/wa/wd).
- Accepts push/pop commands from the interpreter core (loop-bracket return addresses) and keeps the top-of-stack in a register, so `tos` is always valid with zero read latency.
- Drives the memory read and write ports, tracks occupancy, and latches overflow/underflow faults into a FAULT state until cleared.

Parameters:
- DEPTH, 4, memory address width; stack capacity = 2**DEPTH entries (TOS register plus 2**DEPTH-1 memory slots).
- WIDTH, 16, data width of stack entries.

Ports:
- clk  input  1  system clock, rising edge.
- resetq  input  1  reset, asynchronous, active-high.
- push  input  1  push request (sampled when ready=1).
- pop  input  1  pop request (sampled when ready=1).
- push_data  input  WIDTH  value to push.
- clr  input  1  synchronous flush: empties the stack and leaves FAULT.
- ready  output  1  1 in RUN, 0 in FAULT.
- tos  output  WIDTH  current top-of-stack; 0 when empty.
- empty  output  1  count==0.
- full  output  1  count==2**DEPTH.
- count  output  DEPTH+1  number of entries held.
- err_overflow  output  1  sticky; push attempted while full.
- err_underflow  output  1  sticky; pop attempted while empty.
- mem_ra  output  DEPTH  memory read address (combinational).
- mem_rd  input  WIDTH  memory read data (combinational from mem_ra).
- mem_we  output  1  memory write enable.
- mem_wa  output  DEPTH  memory write address.
- mem_wd  output  WIDTH  memory write data.

Behaviour:
- Reset (async, resetq=1): state=RUN, count=0, tos=0, err flags=0, mem_we=0. Outputs hold these values while resetq is high.
- Storage mapping: entry i (0 = bottom) sits at mem[i] for i<count-1. Entry count-1 is held in the tos register.
- mem_ra = count-2 (low DEPTH bits), combinational. mem_we, mem_wa and mem_wd are combinational from the command inputs and the current state.
- All ops take effect at the posedge following the request. There is no multi-cycle op.
- RUN, push only, not full:
  - If count>0: mem_we=1, mem_wa=count-1, mem_wd=tos.
  - tos<=push_data, count<=count+1.
- RUN, pop only, not empty:
  - tos<=(count>=2 ? mem_rd : 0), count<=count-1, mem_we=0.
- RUN, push and pop together = replace: tos<=push_data, count unchanged, no memory write. If empty, this behaves as a plain push.
- RUN, push only, full: no state change except err_overflow<=1 and state<=FAULT. No memory write.
- RUN, pop only, empty: err_underflow<=1, state<=FAULT. tos stays 0.
- FAULT:
  - ready=0; push and pop are ignored; mem_we=0.
  - count, tos and the error flags hold.
- clr (either state): count<=0, tos<=0, err flags<=0, state<=RUN, mem_we=0.
  - clr has priority over push/pop in the same cycle.
  - Memory contents are not scrubbed.
- full and empty are derived combinationally from count. count never exceeds 2**DEPTH. Address arithmetic is modulo 2**DEPTH but is never exercised out of range.
- The value 2**DEPTH is unreachable on mem_wa because a push at count==2**DEPTH is rejected.
- Reset asserted mid-op aborts the op. Any mem write in that cycle is suppressed because mem_we is forced to 0 during reset.

Test Plan:
- DEPTH=2. Reset, then push 0x11, 0x22, 0x33, 0x44.
  - Required: count steps 1..4, tos=0x44, full=1.
  - Memory writes: mem[0]=0x11, mem[1]=0x22, mem[2]=0x33. No write on the first push.
- From full, pop four times.
  - Required: tos reads 0x33, 0x22, 0x11, then 0, and empty=1.
  - No error flags set; ready stays 1.
- From full, push 0x55.
  - Required: err_overflow=1, ready=0, tos=0x44, count=4, mem_we never asserted.
  - Subsequent pops are ignored. Pulse clr -> count=0, ready=1, flags=0.
- Empty stack, pop.
  - Required: err_underflow=1, FAULT. clr together with push 0x77 -> clr wins, count=0.
- Push 0x10, 0x20, then push+pop with 0x99 together.
  - Required: tos=0x99, count=2, mem[0]=0x10, no write in the replace cycle.
- Assert resetq asynchronously mid-push (between clock edges).
  - Required: count=0 and tos=0 immediately; mem_we=0 on the next edge.
